spi_regbank_gen: RTL and testbench

SPI_REGBANK_GEN -- requirements
Module: spi_regbank_gen

---
 rtl/spi_regbank_gen.sv | 265 ++++++++++++++++++++++++++
 tb/tb_spi_regbank_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank_gen.sv
// spi_regbank_gen: SPI mode-0 peripheral that exposes a small bank of registers.
//
// Frame format (MSB first, FRAME_LEN = 1 + ADDR_W + DATA_W bits):
//   R/W (1 = write, 0 = read), address field, data field.
// A write frame commits when ncs rises after exactly FRAME_LEN bits. A read
// frame returns register[address] on cipo during the data phase.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset_n    synchronous active-low reset
//   sclk       asynchronous SPI clock (mode 0)
//   copi       asynchronous SPI data in
//   ncs        asynchronous SPI chip select, active-low
//   cipo       SPI data out (registered)
//   regs_o     flattened registers, register i at [i*DATA_W +: DATA_W]
//   wr_pulse   one-cycle strobe on each committed write
//   wr_addr    address of the most recent committed write
//   frame_err  one-cycle strobe on each wrongly sized frame
module spi_regbank_gen #(
   parameter int NUM_REGS    = 5,
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       sclk,
   input  logic                       copi,
   input  logic                       ncs,
   output logic                       cipo,
   output logic [NUM_REGS*DATA_W-1:0] regs_o,
   output logic                       wr_pulse,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic                       frame_err
);

   localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
   localparam int CNT_W     = $clog2(FRAME_LEN + 2);
   localparam int AW1       = ADDR_W + 1;

   localparam logic [CNT_W-1:0] FRAME_LEN_C  = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_SAT_C    = CNT_W'(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST_C  = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] DATA_START_C = CNT_W'(ADDR_W + 2);
   localparam logic [AW1-1:0]   NUM_REGS_C   = AW1'(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // synchronizers and edge-detect history
   logic [SYNC_STAGES-1:0] sclk_sync_r;
   logic [SYNC_STAGES-1:0] copi_sync_r;
   logic [SYNC_STAGES-1:0] ncs_sync_r;
   logic                   sclk_prev_r;
   logic                   ncs_prev_r;
   logic                   sclk_rise_s;
   logic                   sclk_fall_s;
   logic                   ncs_rise_s;
   logic                   ncs_fall_s;
   logic                   copi_s;

   // FSM
   state_t state_r;
   state_t state_nxt_s;
   logic   start_s;
   logic   shift_en_s;
   logic   enter_commit_s;
   logic   commit_s;

   // datapath
   logic [CNT_W-1:0]                cnt_r;
   logic [CNT_W-1:0]                cnt_nxt_s;
   logic [FRAME_LEN-1:0]            rx_r;
   logic [FRAME_LEN-1:0]            rx_nxt_s;
   logic [ADDR_W-1:0]               rx_addr_nxt_s;
   logic                            wr_ok_s;
   logic [DATA_W-1:0]               tx_r;
   logic [DATA_W-1:0]               tx_nxt_s;
   logic [DATA_W-1:0]               rd_data_s;
   logic                            addr_done_r;
   logic                            cipo_r;
   logic                            wr_pulse_r;
   logic                            frame_err_r;
   logic [ADDR_W-1:0]               wr_addr_r;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs_r;

   assign copi_s      = copi_sync_r[SYNC_STAGES-1];
   assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-1] & ~sclk_prev_r;
   assign sclk_fall_s = ~sclk_sync_r[SYNC_STAGES-1] & sclk_prev_r;
   assign ncs_rise_s  = ncs_sync_r[SYNC_STAGES-1] & ~ncs_prev_r;
   assign ncs_fall_s  = ~ncs_sync_r[SYNC_STAGES-1] & ncs_prev_r;

   // Input synchronizers plus one history flop for edge detection.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sclk_sync_r <= '0;
         copi_sync_r <= '0;
         ncs_sync_r  <= '0;
         sclk_prev_r <= 1'b0;
         ncs_prev_r  <= 1'b0;
      end else begin
         sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
         copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], copi};
         ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], ncs};
         sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
         ncs_prev_r  <= ncs_sync_r[SYNC_STAGES-1];
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (ncs_fall_s) begin
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (ncs_rise_s) begin
               state_nxt_s = COMMIT;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         COMMIT:  state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM output decode: datapath control strobes.
   always_comb begin
      start_s        = 1'b0;
      shift_en_s     = 1'b0;
      enter_commit_s = 1'b0;
      commit_s       = 1'b0;
      case (state_r)
         IDLE:   start_s = ncs_fall_s;
         SHIFT: begin
            shift_en_s     = 1'b1;
            enter_commit_s = ncs_rise_s;
         end
         COMMIT:  commit_s = 1'b1;
         default: start_s  = 1'b0;
      endcase
   end

   // Next receive-register and bit-counter values; the counter saturates one past a full frame.
   always_comb begin
      cnt_nxt_s = cnt_r;
      rx_nxt_s  = rx_r;
      if (start_s) begin
         cnt_nxt_s = '0;
         rx_nxt_s  = '0;
      end else if (shift_en_s && sclk_rise_s) begin
         rx_nxt_s = {rx_r[FRAME_LEN-2:0], copi_s};
         if (cnt_r == CNT_SAT_C) begin
            cnt_nxt_s = cnt_r;
         end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_nxt_s = cnt_r;
         rx_nxt_s  = rx_r;
      end
   end

   // Commit decision is taken on the frame as it will stand when COMMIT is entered,
   // so wr_pulse can be a flop that is high during the COMMIT cycle itself.
   assign rx_addr_nxt_s = rx_nxt_s[FRAME_LEN-2 -: ADDR_W];
   assign wr_ok_s       = (cnt_nxt_s == FRAME_LEN_C) && rx_nxt_s[FRAME_LEN-1] &&
                          ({1'b0, rx_addr_nxt_s} < NUM_REGS_C);

   // Read mux; right after the address phase rx_r holds {R/W, address} in its low bits.
   // Unimplemented addresses fall through to zero.
   always_comb begin
      rd_data_s = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rx_r[ADDR_W-1:0] == ADDR_W'(i)) begin
            rd_data_s = regs_r[i];
         end else begin
            rd_data_s = rd_data_s;
         end
      end
   end

   // Transmit register: load on read frames, shift on falls that follow data-bit rises.
   always_comb begin
      tx_nxt_s = tx_r;
      if (!shift_en_s || enter_commit_s) begin
         tx_nxt_s = '0;
      end else if (addr_done_r && !rx_r[ADDR_W]) begin
         tx_nxt_s = rd_data_s;
      end else if (sclk_fall_s && (cnt_r >= DATA_START_C)) begin
         tx_nxt_s = {tx_r[DATA_W-2:0], 1'b0};
      end else begin
         tx_nxt_s = tx_r;
      end
   end

   // Frame datapath registers and status strobes.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_r       <= '0;
         rx_r        <= '0;
         tx_r        <= '0;
         cipo_r      <= 1'b0;
         addr_done_r <= 1'b0;
         wr_pulse_r  <= 1'b0;
         frame_err_r <= 1'b0;
         wr_addr_r   <= '0;
      end else begin
         cnt_r       <= cnt_nxt_s;
         rx_r        <= rx_nxt_s;
         tx_r        <= tx_nxt_s;
         cipo_r      <= tx_nxt_s[DATA_W-1];
         addr_done_r <= shift_en_s && sclk_rise_s && (cnt_r == ADDR_LAST_C);
         wr_pulse_r  <= enter_commit_s && wr_ok_s;
         frame_err_r <= enter_commit_s && (cnt_nxt_s != FRAME_LEN_C);
         if (enter_commit_s && wr_ok_s) begin
            wr_addr_r <= rx_addr_nxt_s;
         end else begin
            wr_addr_r <= wr_addr_r;
         end
      end
   end

   // Register bank: written only in COMMIT of a valid write frame.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         regs_r <= '0;
      end else if (commit_s && wr_pulse_r) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr_r == ADDR_W'(i)) begin
               regs_r[i] <= rx_r[DATA_W-1:0];
            end else begin
               regs_r[i] <= regs_r[i];
            end
         end
      end else begin
         regs_r <= regs_r;
      end
   end

   assign cipo      = cipo_r;
   assign regs_o    = regs_r;
   assign wr_pulse  = wr_pulse_r;
   assign wr_addr   = wr_addr_r;
   assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_regbank_gen.sv
// Testbench for spi_regbank_gen: a default build (A) and a 16x16 build (B)
// share sclk/copi and have separate chip selects. Expected values come from
// a register-array model of the bank updated by frame-level rules.
module tb_spi_regbank_gen;

   localparam int H = 6;   // sclk half-period in clk cycles

   logic clk = 1'b0;
   logic reset_n;
   logic sclk, copi, ncs_a, ncs_b;
   logic cipo_a, cipo_b;
   logic [39:0]  regs_a;
   logic [255:0] regs_b;
   logic wr_pulse_a, wr_pulse_b, frame_err_a, frame_err_b;
   logic [6:0] wr_addr_a, wr_addr_b;

   spi_regbank_gen dut_a (
      .clk(clk), .reset_n(reset_n), .sclk(sclk), .copi(copi), .ncs(ncs_a),
      .cipo(cipo_a), .regs_o(regs_a), .wr_pulse(wr_pulse_a),
      .wr_addr(wr_addr_a), .frame_err(frame_err_a)
   );

   spi_regbank_gen #(.NUM_REGS(16), .DATA_W(16)) dut_b (
      .clk(clk), .reset_n(reset_n), .sclk(sclk), .copi(copi), .ncs(ncs_b),
      .cipo(cipo_b), .regs_o(regs_b), .wr_pulse(wr_pulse_b),
      .wr_addr(wr_addr_b), .frame_err(frame_err_b)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // observed strobe cycle counts
   int wp_a = 0, fe_a = 0, wp_b = 0, fe_b = 0;
   // model
   logic [7:0]  model_a [5];
   logic [15:0] model_b [16];
   int exp_wp_a = 0, exp_fe_a = 0, exp_wp_b = 0, exp_fe_b = 0;
   logic [6:0] exp_wa_a = 7'd0, exp_wa_b = 7'd0;
   logic [63:0] cap;

   always @(negedge clk) begin
      if (wr_pulse_a)  wp_a++;
      if (frame_err_a) fe_a++;
      if (wr_pulse_b)  wp_b++;
      if (frame_err_b) fe_b++;
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [255:0] flat(input int tgt);
      logic [255:0] f = '0;
      if (tgt == 0) begin
         for (int i = 0; i < 5; i++) f[i*8 +: 8] = model_a[i];
      end else begin
         for (int i = 0; i < 16; i++) f[i*16 +: 16] = model_b[i];
      end
      return f;
   endfunction

   function automatic int dw(input int tgt);
      return (tgt == 0) ? 8 : 16;
   endfunction

   function automatic logic [63:0] mk_frame(input int tgt, input logic rw,
                                            input logic [6:0] addr, input logic [15:0] data);
      logic [63:0] f;
      f = (64'(rw) << (7 + dw(tgt))) | (64'(addr) << dw(tgt));
      f = f | (64'(data) & ((64'd1 << dw(tgt)) - 64'd1));
      return f;
   endfunction

   task automatic set_ncs(input int tgt, input logic v);
      if (tgt == 0) ncs_a = v; else ncs_b = v;
   endtask

   // Bit i of a total-bit frame goes out on the i-th rise; cipo sampled just before it.
   task automatic spi_bits(input int tgt, input int tot, input logic [63:0] frame,
                           input int from, input int upto);
      for (int i = from; i < upto; i++) begin
         copi = frame[tot-1-i];
         wait_clk(H);
         cap[tot-1-i] = (tgt == 0) ? cipo_a : cipo_b;
         sclk = 1'b1;
         wait_clk(H);
         sclk = 1'b0;
      end
   endtask

   task automatic spi_frame(input int tgt, input int tot, input logic [63:0] frame);
      cap = '0;
      set_ncs(tgt, 1'b0);
      wait_clk(H);
      spi_bits(tgt, tot, frame, 0, tot);
      wait_clk(H);
      set_ncs(tgt, 1'b1);
      wait_clk(12);
   endtask

   task automatic check_state(input int tgt, input string tag);
      if (tgt == 0) begin
         chk({tag, " regs_a"},    256'(regs_a),    flat(0));
         chk({tag, " wp_a"},      256'(wp_a),      256'(exp_wp_a));
         chk({tag, " fe_a"},      256'(fe_a),      256'(exp_fe_a));
         chk({tag, " wr_addr_a"}, 256'(wr_addr_a), 256'(exp_wa_a));
      end else begin
         chk({tag, " regs_b"},    regs_b,          flat(1));
         chk({tag, " wp_b"},      256'(wp_b),      256'(exp_wp_b));
         chk({tag, " fe_b"},      256'(fe_b),      256'(exp_fe_b));
         chk({tag, " wr_addr_b"}, 256'(wr_addr_b), 256'(exp_wa_b));
      end
   endtask

   task automatic do_write(input int tgt, input logic [6:0] addr, input logic [15:0] data,
                           input string tag);
      int tot = 8 + dw(tgt);
      spi_frame(tgt, tot, mk_frame(tgt, 1'b1, addr, data));
      if (tgt == 0 && addr < 7'd5) begin
         model_a[addr] = data[7:0];
         exp_wp_a++;
         exp_wa_a = addr;
      end else if (tgt == 1 && addr < 7'd16) begin
         model_b[addr] = data;
         exp_wp_b++;
         exp_wa_b = addr;
      end
      chk({tag, " cipo quiet"}, 256'(cap), 256'd0);
      check_state(tgt, tag);
   endtask

   task automatic do_read(input int tgt, input logic [6:0] addr, input string tag);
      int tot = 8 + dw(tgt);
      logic [15:0] exp_d;
      logic [63:0] mask;
      exp_d = 16'd0;
      if (tgt == 0 && addr < 7'd5) exp_d = {8'd0, model_a[addr]};
      if (tgt == 1 && addr < 7'd16) exp_d = model_b[addr];
      spi_frame(tgt, tot, mk_frame(tgt, 1'b0, addr, 16'($urandom)));
      mask = (64'd1 << dw(tgt)) - 64'd1;
      chk({tag, " rdata"},      256'(cap & mask),  256'(exp_d));
      chk({tag, " addr phase"}, 256'(cap & ~mask), 256'd0);
      check_state(tgt, tag);
   endtask

   task automatic do_bad_len(input int tgt, input int nbits, input string tag);
      spi_frame(tgt, nbits, 64'($urandom) | (64'd1 << (nbits - 1)));
      if (tgt == 0) exp_fe_a++; else exp_fe_b++;
      check_state(tgt, tag);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 5; i++)  model_a[i] = 8'd0;
      for (int i = 0; i < 16; i++) model_b[i] = 16'd0;
      exp_wa_a = 7'd0;
      exp_wa_b = 7'd0;
   endtask

   initial begin
      logic [6:0]  ra;
      logic [15:0] rd;
      reset_n = 1'b0;
      sclk = 1'b0; copi = 1'b0; ncs_a = 1'b1; ncs_b = 1'b1;
      clear_model();
      wait_clk(5);
      // reset state
      chk("reset regs_a",  256'(regs_a), 256'd0);
      chk("reset regs_b",  regs_b, 256'd0);
      chk("reset outs_a",  256'({cipo_a, wr_pulse_a, frame_err_a, wr_addr_a}), 256'd0);
      chk("reset outs_b",  256'({cipo_b, wr_pulse_b, frame_err_b, wr_addr_b}), 256'd0);
      reset_n = 1'b1;
      wait_clk(6);

      // basic write and readback
      do_write(0, 7'h04, 16'h00A5, "wr a4");
      chk("wr a4 slice", 256'(regs_a[39:32]), 256'h0A5);
      do_read(0, 7'h04, "rd a4");
      // out-of-range address
      do_write(0, 7'h10, 16'h00FF, "wr a10");
      do_read(0, 7'h10, "rd a10");
      // wrong-length frames, register 0 holds a value first
      do_write(0, 7'h00, 16'h005A, "wr a0");
      do_bad_len(0, 12, "short12");
      do_bad_len(0, 17, "long17");
      do_bad_len(0, 21, "long21");

      // reset in the middle of a write frame, ncs held low through release
      cap = '0;
      ncs_a = 1'b0;
      wait_clk(H);
      spi_bits(0, 16, mk_frame(0, 1'b1, 7'h01, 16'h003C), 0, 8);
      reset_n = 1'b0;
      wait_clk(3);
      clear_model();
      reset_n = 1'b1;
      spi_bits(0, 16, mk_frame(0, 1'b1, 7'h01, 16'h003C), 8, 16);
      wait_clk(H);
      ncs_a = 1'b1;
      wait_clk(12);
      check_state(0, "mid reset");
      check_state(1, "mid reset");
      do_write(0, 7'h01, 16'h003C, "wr a1 after rst");

      // wide build
      do_write(1, 7'h0F, 16'hBEEF, "wr b15");
      chk("wr b15 slice", 256'(regs_b[255:240]), 256'hBEEF);
      do_read(1, 7'h0F, "rd b15");
      do_bad_len(1, 23, "b short23");

      // randomized traffic
      for (int n = 0; n < 12; n++) begin
         ra = 7'($urandom_range(0, 7));
         rd = 16'($urandom);
         if ($urandom_range(0, 1) == 1) do_write(0, ra, rd, "rand a wr");
         else                           do_read(0, ra, "rand a rd");
      end
      for (int n = 0; n < 8; n++) begin
         ra = 7'($urandom_range(0, 19));
         rd = 16'($urandom);
         if ($urandom_range(0, 1) == 1) do_write(1, ra, rd, "rand b wr");
         else                           do_read(1, ra, "rand b rd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
